// File: rtl/signedness_pkg.sv
// Shared widths and helpers for the signed/unsigned multiplier pair.
// Default operand widths and the full-precision product width rule.
package signedness_pkg;

    localparam int AW_DEF = 3;
    localparam int BW_DEF = 2;

    function automatic int prod_w(input int aw, input int bw);
        return aw + bw;
    endfunction

endpackage

// File: rtl/signedness_mul_core.sv
// Combinational full-precision multiply with explicit operand extension.
// SIGNED selects sign- or zero-extension of both operands to CW bits.
module mul_core
    import signedness_pkg::*;
#(
    parameter  int AW     = AW_DEF,
    parameter  int BW     = BW_DEF,
    parameter  bit SIGNED = 1'b1,
    localparam int CW     = prod_w(AW, BW)
) (
    input  logic [AW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    output logic [CW-1:0] p_o
);

    logic          a_fill;
    logic          b_fill;
    logic [CW-1:0] a_ext;
    logic [CW-1:0] b_ext;

    assign a_fill = SIGNED ? a_i[AW-1] : 1'b0;
    assign b_fill = SIGNED ? b_i[BW-1] : 1'b0;

    assign a_ext = {{(CW-AW){a_fill}}, a_i};
    assign b_ext = {{(CW-BW){b_fill}}, b_i};

    // Low CW bits of the extended product are exact two's complement.
    assign p_o = a_ext * b_ext;

endmodule

// File: rtl/signedness.sv
// Registered signed and unsigned multiplier pair sharing operand widths.
// Each path is one mul_core followed by an async-reset output register.
module signedness
    import signedness_pkg::*;
#(
    parameter  int AW = AW_DEF,
    parameter  int BW = BW_DEF,
    localparam int CW = prod_w(AW, BW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [CW-1:0] c,
    input  logic [AW-1:0] au,
    input  logic [BW-1:0] bu,
    output logic [CW-1:0] cu
);

    logic [CW-1:0] c_d;
    logic [CW-1:0] c_q;
    logic [CW-1:0] cu_d;
    logic [CW-1:0] cu_q;

    mul_core #(
        .AW     (AW),
        .BW     (BW),
        .SIGNED (1'b1)
    ) u_mul_s (
        .a_i (a),
        .b_i (b),
        .p_o (c_d)
    );

    mul_core #(
        .AW     (AW),
        .BW     (BW),
        .SIGNED (1'b0)
    ) u_mul_u (
        .a_i (au),
        .b_i (bu),
        .p_o (cu_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q  <= '0;
            cu_q <= '0;
        end else begin
            c_q  <= c_d;
            cu_q <= cu_d;
        end
    end

    assign c  = c_q;
    assign cu = cu_q;

endmodule

// File: tb/tb_signedness.sv
// Scoreboard bench for signedness: driver pushes expected products,
// monitor pops and compares one cycle later.
module tb_signedness;

    logic       clk;
    logic       rst_n;
    logic [2:0] a;
    logic [1:0] b;
    logic [4:0] c;
    logic [2:0] au;
    logic [1:0] bu;
    logic [4:0] cu;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] c;
        logic [4:0] cu;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    signedness dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .au    (au),
        .bu    (bu),
        .cu    (cu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [4:0] act,
                       input logic [4:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, act, req);
        end
    endtask

    // Reference: operands interpreted as integers, product reduced mod 32.
    function automatic exp_t model(input int ta, input int tb,
                                   input int tau, input int tbu,
                                   input string tag);
        exp_t e;
        int sa, sb, p, pu;
        sa = (ta >= 4) ? ta - 8 : ta;
        sb = (tb >= 2) ? tb - 4 : tb;
        p  = sa * sb;
        pu = tau * tbu;
        e.c   = p[4:0];
        e.cu  = pu[4:0];
        e.tag = tag;
        return e;
    endfunction

    task automatic drive(input int ta, input int tb, input int tau,
                         input int tbu, input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        a  = 3'(ta);
        b  = 2'(tb);
        au = 3'(tau);
        bu = 2'(tbu);
        sb_q.push_back(model(ta, tb, tau, tbu, tag));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.tag, ".c"}, c, e.c);
                chk({e.tag, ".cu"}, cu, e.cu);
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        a  = '0;
        b  = '0;
        au = '0;
        bu = '0;
        #3;
        chk("reset.c", c, 5'd0);
        chk("reset.cu", cu, 5'd0);
        @(posedge clk);
        #1;
        chk("reset_hold.c", c, 5'd0);
        chk("reset_hold.cu", cu, 5'd0);

        drive(4, 1, 4, 1, "t1_neg4x1");
        drive(6, 2, 6, 2, "t2_neg2xneg2");
        drive(4, 2, 7, 3, "t3_extremes");

        for (int i = 0; i < 32; i++) begin
            drive(i >> 2, i & 3, ((i * 7 + 3) % 32) >> 2,
                  ((i * 7 + 3) % 32) & 3, $sformatf("sweep%0d", i));
            if (i == 16) begin
                #2;
                rst_n = 1'b0;
                sb_q.delete();
                #1;
                chk("async_rst.c", c, 5'd0);
                chk("async_rst.cu", cu, 5'd0);
                @(posedge clk);
                #1;
                chk("rst_held.c", c, 5'd0);
                chk("rst_held.cu", cu, 5'd0);
            end
        end

        // Re-issue the full sweep so the pair lost to reset is covered.
        for (int i = 0; i < 32; i++) begin
            drive(i >> 2, i & 3, i >> 2, i & 3, $sformatf("same%0d", i));
        end

        for (int k = 0; k < 5; k++) begin
            drive(5, 3, 7, 2, $sformatf("hold%0d", k));
        end

        for (int k = 0; k < 100; k++) begin
            drive($urandom_range(7), $urandom_range(3),
                  $urandom_range(7), $urandom_range(3),
                  $sformatf("rnd%0d", k));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
